// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the IF/ID
// hand-off. The sequencer drives it through the master modport; memory and
// the IF/ID register sit on the slave side.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   if_valid;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0]  if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: decides each cycle whether the PC advances, redirects or
// holds, drives the instruction-memory request and presents fetched
// instructions to IF/ID, parking one that arrives while decode is stalled.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | one idle cycle after reset, all strobes low
// FETCH | request outstanding at pc_current, waiting for imem_ready
// HOLD  | fetched instruction parked while decode stalls, no request
module fetch_sequencer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INSTR_WIDTH  = 32,
  parameter int PC_INCREMENT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_current,
  output logic                  pc_enable,
  output logic [ADDR_WIDTH-1:0] pc_next,
  fetch_sequencer_if.master     bus,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  flush
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fsm_t;

  fsm_t                   fsm;
  logic                   pending_valid;
  logic [ADDR_WIDTH-1:0]  pending_target;
  logic [INSTR_WIDTH-1:0] hold_instr;
  logic [ADDR_WIDTH-1:0]  hold_pc;
  logic [ADDR_WIDTH-1:0]  pc_seq;

  // Sequential successor; wraps naturally at the top of the address space.
  assign pc_seq = pc_current + ADDR_WIDTH'(PC_INCREMENT);

  // State and side registers: redirect remembered until the outstanding
  // fetch completes, and the instruction parked during a decode stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm            <= BOOT;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      hold_instr     <= '0;
      hold_pc        <= '0;
    end else begin
      case (fsm)
        BOOT: fsm <= FETCH;
        FETCH: begin
          if (branch_taken) begin
            // A redirect that cannot load yet waits for the in-flight
            // response; a newer one replaces an older one.
            pending_valid <= !bus.imem_ready;
            if (!bus.imem_ready) pending_target <= branch_target;
          end else if (bus.imem_ready) begin
            if (pending_valid) begin
              pending_valid <= 1'b0;
            end else if (stall) begin
              hold_instr <= bus.imem_rdata;
              hold_pc    <= pc_current;
              fsm        <= HOLD;
            end
          end
        end
        HOLD: begin
          if (branch_taken || !stall) fsm <= FETCH;
        end
        default: fsm <= BOOT;
      endcase
    end
  end

  // Outputs are decoded from the registered state and the current inputs so
  // a single-cycle memory yields one instruction per clock.
  always_comb begin
    pc_enable     = 1'b0;
    pc_next       = pc_seq;
    flush         = 1'b0;
    bus.imem_req  = 1'b0;
    bus.imem_addr = pc_current;
    bus.if_valid  = 1'b0;
    bus.if_instr  = '0;
    bus.if_pc     = '0;
    if (reset) begin
      pc_next       = '0;
      bus.imem_addr = '0;
    end else begin
      case (fsm)
        FETCH: begin
          bus.imem_req = 1'b1;
          if (branch_taken) begin
            flush = 1'b1;
            if (bus.imem_ready) begin
              pc_enable = 1'b1;
              pc_next   = branch_target;
            end
          end else if (bus.imem_ready) begin
            pc_enable = 1'b1;
            if (pending_valid) begin
              // Response belongs to the wrong path: drop it and redirect.
              pc_next = pending_target;
            end else if (!stall) begin
              bus.if_valid = 1'b1;
              bus.if_instr = bus.imem_rdata;
              bus.if_pc    = pc_current;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            flush     = 1'b1;
            pc_enable = 1'b1;
            pc_next   = branch_target;
          end else if (!stall) begin
            bus.if_valid = 1'b1;
            bus.if_instr = hold_instr;
            bus.if_pc    = hold_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by randomized
// traffic checked against a transaction-level reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic        pc_enable;
  logic [31:0] pc_next;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .pc_current   (pc_current),
    .pc_enable    (pc_enable),
    .pc_next      (pc_next),
    .bus          (bus),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  // {imem_req, pc_enable, if_valid, flush}
  wire [3:0] strobes = {bus.imem_req, pc_enable, bus.if_valid, flush};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_current = 32'h1234; stall = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h88;
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'hA5A5A5A5;
    settle();
    n_checks++;
    if ({strobes, pc_next, bus.imem_addr, bus.if_instr, bus.if_pc} !== 132'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: strobes=%b pc_next=%h addr=%h instr=%h ifpc=%h, required all zero",
               strobes, pc_next, bus.imem_addr, bus.if_instr, bus.if_pc);
    end
    step();
    reset = 1'b0; pc_current = 32'h0;
    settle();
    n_checks++;
    if (strobes !== 4'b0000) begin
      n_fail++;
      $display("FAIL boot_cycle: strobes=%b, required 0000 (branch ignored)", strobes);
    end
    step();
    branch_taken = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      bus.imem_rdata = $urandom;
      settle();
      n_checks++;
      if (strobes !== 4'b1110 || pc_next !== 32'((i + 1) * 4) ||
          bus.if_pc !== pc_current || bus.if_instr !== bus.imem_rdata ||
          bus.imem_addr !== pc_current) begin
        n_fail++;
        $display("FAIL seq_fetch_%0d: strobes=%b pc_next=%h if_pc=%h, required 1110 pc_next=%h if_pc=%h",
                 i, strobes, pc_next, bus.if_pc, 32'((i + 1) * 4), pc_current);
      end
      step();
      pc_current = 32'((i + 1) * 4);
    end
  endtask

  task automatic test_mem_wait();
    pc_current = 32'h100; bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (strobes !== 4'b1000 || bus.imem_addr !== 32'h100) begin
        n_fail++;
        $display("FAIL wait_%0d: strobes=%b addr=%h, required 1000 addr=00000100", i, strobes, bus.imem_addr);
      end
      step();
    end
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h13579BDF;
    settle();
    n_checks++;
    if (strobes !== 4'b1110 || bus.if_pc !== 32'h100 || pc_next !== 32'h104 ||
        bus.if_instr !== 32'h13579BDF) begin
      n_fail++;
      $display("FAIL wait_done: strobes=%b if_pc=%h pc_next=%h, required 1110 if_pc=00000100 pc_next=00000104",
               strobes, bus.if_pc, pc_next);
    end
    step();
  endtask

  task automatic test_branch_ready();
    pc_current = 32'h10; bus.imem_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h200;
    settle();
    n_checks++;
    if (strobes !== 4'b1101 || pc_next !== 32'h200) begin
      n_fail++;
      $display("FAIL branch_ready: strobes=%b pc_next=%h, required 1101 pc_next=00000200", strobes, pc_next);
    end
    step();
    branch_taken = 1'b0; pc_current = 32'h200;
    settle();
    n_checks++;
    if (strobes !== 4'b1110 || pc_next !== 32'h204) begin
      n_fail++;
      $display("FAIL branch_after: strobes=%b pc_next=%h, required 1110 pc_next=00000204", strobes, pc_next);
    end
    step();
    pc_current = 32'h204;
  endtask

  task automatic test_pending_branch();
    pc_current = 32'h40; bus.imem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h300;
    settle();
    n_checks++;
    if (strobes !== 4'b1001) begin
      n_fail++;
      $display("FAIL pend_flush: strobes=%b, required 1001", strobes);
    end
    step();
    branch_taken = 1'b0;
    settle();
    n_checks++;
    if (strobes !== 4'b1000) begin
      n_fail++;
      $display("FAIL pend_wait: strobes=%b, required 1000 (single flush)", strobes);
    end
    step();
    bus.imem_ready = 1'b1;
    settle();
    n_checks++;
    if (strobes !== 4'b1100 || pc_next !== 32'h300) begin
      n_fail++;
      $display("FAIL pend_redirect: strobes=%b pc_next=%h, required 1100 pc_next=00000300", strobes, pc_next);
    end
    step();
    pc_current = 32'h300; bus.imem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h350;
    step();
    branch_target = 32'h400;
    settle();
    n_checks++;
    if (strobes !== 4'b1001) begin
      n_fail++;
      $display("FAIL pend_second_flush: strobes=%b, required 1001", strobes);
    end
    step();
    branch_taken = 1'b0; bus.imem_ready = 1'b1;
    settle();
    n_checks++;
    if (strobes !== 4'b1100 || pc_next !== 32'h400) begin
      n_fail++;
      $display("FAIL pend_overwrite: strobes=%b pc_next=%h, required 1100 pc_next=00000400", strobes, pc_next);
    end
    step();
    pc_current = 32'h400;
    settle();
    n_checks++;
    if (strobes !== 4'b1110 || pc_next !== 32'h404) begin
      n_fail++;
      $display("FAIL pend_cleared: strobes=%b pc_next=%h, required 1110 pc_next=00000404", strobes, pc_next);
    end
    step();
  endtask

  task automatic test_stall_hold();
    pc_current = 32'h20; bus.imem_ready = 1'b1; stall = 1'b1;
    bus.imem_rdata = 32'hE3A00001;
    settle();
    n_checks++;
    if (strobes !== 4'b1100 || pc_next !== 32'h24) begin
      n_fail++;
      $display("FAIL stall_capture: strobes=%b pc_next=%h, required 1100 pc_next=00000024", strobes, pc_next);
    end
    step();
    pc_current = 32'h24; bus.imem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if (strobes !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold_stall_%0d: strobes=%b, required 0000", i, strobes);
      end
      step();
    end
    stall = 1'b0; bus.imem_ready = 1'b0;
    settle();
    n_checks++;
    if (strobes !== 4'b0010 || bus.if_instr !== 32'hE3A00001 || bus.if_pc !== 32'h20) begin
      n_fail++;
      $display("FAIL hold_release: strobes=%b instr=%h if_pc=%h, required 0010 instr=e3a00001 if_pc=00000020",
               strobes, bus.if_instr, bus.if_pc);
    end
    step();
    bus.imem_ready = 1'b1; stall = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    step();
    pc_current = 32'h28; bus.imem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h500;
    settle();
    n_checks++;
    if (strobes !== 4'b0101 || pc_next !== 32'h500) begin
      n_fail++;
      $display("FAIL hold_branch: strobes=%b pc_next=%h, required 0101 pc_next=00000500", strobes, pc_next);
    end
    step();
    branch_taken = 1'b0; stall = 1'b0; pc_current = 32'h500;
    settle();
    n_checks++;
    if (strobes !== 4'b1000 || bus.imem_addr !== 32'h500) begin
      n_fail++;
      $display("FAIL hold_killed: strobes=%b addr=%h, required 1000 addr=00000500", strobes, bus.imem_addr);
    end
    step();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0BADF00D;
    settle();
    n_checks++;
    if (strobes !== 4'b1110 || bus.if_pc !== 32'h500 || bus.if_instr !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL hold_resume: strobes=%b if_pc=%h instr=%h, required 1110 if_pc=00000500 instr=0badf00d",
               strobes, bus.if_pc, bus.if_instr);
    end
    step();
  endtask

  task automatic test_wrap();
    pc_current = 32'hFFFFFFFC; bus.imem_ready = 1'b1; stall = 1'b0;
    settle();
    n_checks++;
    if (strobes !== 4'b1110 || pc_next !== 32'h0 || bus.if_pc !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL wrap: strobes=%b pc_next=%h, required 1110 pc_next=00000000", strobes, pc_next);
    end
    step();
    pc_current = 32'h0;
  endtask

  task automatic test_reset_mid_wait();
    pc_current = 32'h60; bus.imem_ready = 1'b0;
    step();
    reset = 1'b1;
    settle();
    n_checks++;
    if ({strobes, pc_next, bus.imem_addr} !== 68'd0) begin
      n_fail++;
      $display("FAIL rst_mid: strobes=%b pc_next=%h addr=%h, required all zero", strobes, pc_next, bus.imem_addr);
    end
    step();
    reset = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 32'h11111111;
    settle();
    n_checks++;
    if (strobes !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_late_ready: strobes=%b, required 0000", strobes);
    end
    step();
    bus.imem_ready = 1'b0;
    settle();
    n_checks++;
    if (strobes !== 4'b1000 || bus.imem_addr !== 32'h60) begin
      n_fail++;
      $display("FAIL rst_refetch: strobes=%b addr=%h, required 1000 addr=00000060", strobes, bus.imem_addr);
    end
    step();
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } parked_t;

  // Reference model in transaction terms: a boot flag, a queue of at most one
  // parked instruction and a queue of at most one deferred redirect.
  task automatic test_random();
    bit          booting = 1'b1;
    parked_t     parked_q[$];
    logic [31:0] redirect_q[$];
    logic [3:0]  e_str;
    logic [31:0] e_next, e_addr, e_instr, e_pc;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pc_current = {$urandom, 2'b00};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      branch_taken   = ($urandom_range(0, 6) == 0);
      branch_target  = {$urandom, 2'b00};
      bus.imem_rdata = $urandom;
      e_str = 4'b0000; e_next = pc_current + 32'd4; e_addr = pc_current;
      e_instr = 32'h0; e_pc = 32'h0;
      if (reset) begin
        e_next = 32'h0; e_addr = 32'h0;
      end else if (booting) begin
      end else if (parked_q.size() != 0) begin
        if (branch_taken) begin
          e_str = 4'b0101; e_next = branch_target;
        end else if (!stall) begin
          e_str = 4'b0010; e_instr = parked_q[0].instr; e_pc = parked_q[0].pc;
        end
      end else begin
        e_str[3] = 1'b1;
        if (branch_taken) begin
          e_str[0] = 1'b1;
          if (bus.imem_ready) begin
            e_str[2] = 1'b1; e_next = branch_target;
          end
        end else if (bus.imem_ready) begin
          e_str[2] = 1'b1;
          if (redirect_q.size() != 0) e_next = redirect_q[0];
          else if (!stall) begin
            e_str[1] = 1'b1; e_instr = bus.imem_rdata; e_pc = pc_current;
          end
        end
      end
      settle();
      n_checks++;
      if ({strobes, pc_next, bus.imem_addr, bus.if_instr, bus.if_pc} !==
          {e_str, e_next, e_addr, e_instr, e_pc}) begin
        n_fail++;
        $display("FAIL rand_cyc%0d: got str=%b next=%h addr=%h instr=%h pc=%h, required str=%b next=%h addr=%h instr=%h pc=%h",
                 cyc, strobes, pc_next, bus.imem_addr, bus.if_instr, bus.if_pc,
                 e_str, e_next, e_addr, e_instr, e_pc);
      end
      if (reset) begin
        booting = 1'b1; parked_q.delete(); redirect_q.delete();
      end else if (booting) begin
        booting = 1'b0;
      end else if (parked_q.size() != 0) begin
        if (branch_taken || !stall) parked_q.delete();
      end else if (branch_taken) begin
        redirect_q.delete();
        if (!bus.imem_ready) redirect_q.push_back(branch_target);
      end else if (bus.imem_ready) begin
        if (redirect_q.size() != 0) redirect_q.delete();
        else if (stall) parked_q.push_back('{instr: bus.imem_rdata, pc: pc_current});
      end
      step();
      if (e_str[2]) pc_current = e_next;
    end
    reset = 1'b0; branch_taken = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mem_wait();
    test_branch_ready();
    test_pending_branch();
    test_stall_hold();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
